// File: rtl/debounce_onepulse.sv
// debounce_onepulse: synchronizes a bouncing push-button, debounces it by
// sampling on rising edges of a slow tick, and emits one-cycle press,
// release and (optionally) long-press pulses.
// Optional feature macro: DEBOUNCE_LONG_PRESS_EN enables the long-press
// counter; without it long_pulse is tied to 0 and no counter exists.
module debounce_onepulse #(
    parameter int DB_SAMPLES = 4,
    parameter int LONG_TICKS = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_in,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    // Catch out-of-range parameters at elaboration.
    if (DB_SAMPLES < 2 || DB_SAMPLES > 16) begin : g_bad_db
        $error("DB_SAMPLES must be in 2..16");
    end
    if (LONG_TICKS < 1 || LONG_TICKS > 65535) begin : g_bad_long
        $error("LONG_TICKS must be in 1..65535");
    end

    typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} state_t;

    logic                  sync1_q, sync2_q;
    logic                  tick_q;
    logic                  tick_rise;
    logic [DB_SAMPLES-1:0] samp_q, samp_d;
    state_t                state_q;
    logic                  level_q, press_q, rel_q;

    assign tick_rise = tick_in & ~tick_q;

    // Two-flop synchronizer for the raw button plus the tick edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            tick_q  <= tick_in;
        end
    end

    // Shift the synchronized button in (LSB newest) only on a tick rise.
    always_comb begin
        samp_d = samp_q;
        if (tick_rise) samp_d = {samp_q[DB_SAMPLES-2:0], sync2_q};
    end

    // Sample history register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) samp_q <= '0;
        else        samp_q <= samp_d;
    end

    // Debounce FSM; level and pulses are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RELEASED;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            case (state_q)
                RELEASED: if (&samp_q) begin
                    state_q <= PRESSED;
                    level_q <= 1'b1;
                    press_q <= 1'b1;
                end
                PRESSED: if (~|samp_q) begin
                    state_q <= RELEASED;
                    level_q <= 1'b0;
                    rel_q   <= 1'b1;
                end
                default: begin
                    state_q <= RELEASED;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam logic [15:0] LONG_TGT = 16'(LONG_TICKS);

    logic [15:0] lcnt_q, lcnt_d;
    logic        long_q;

    // Count tick rises while pressed, saturating; held at zero when released
    // so every press starts counting from zero.
    always_comb begin
        lcnt_d = lcnt_q;
        if (state_q != PRESSED)                     lcnt_d = '0;
        else if (tick_rise && lcnt_q != 16'hFFFF)   lcnt_d = lcnt_q + 16'd1;
    end

    // Counter register; long pulse fires only on the step onto the target,
    // so it cannot repeat within one press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcnt_q <= '0;
            long_q <= 1'b0;
        end else begin
            lcnt_q <= lcnt_d;
            long_q <= (lcnt_d == LONG_TGT) && (lcnt_q != LONG_TGT);
        end
    end

    assign long_pulse = long_q;
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_onepulse.sv
// Bench for debounce_onepulse: table of per-tick button patterns with the
// tick index at which each pulse must appear, plus hand-written sequences
// for reset, bounce, frozen tick and reset-while-pressed. Expected pulses
// are queued when the completing tick is driven and matched when seen.
module tb_debounce_onepulse;

    localparam int TP = 64;
    localparam int K_PRESS = 0, K_REL = 1, K_LONG = 2;
`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, tick_in = 1'b0, btn_in = 1'b0;
    logic btn_level, press_pulse, release_pulse, long_pulse;

    debounce_onepulse #(.DB_SAMPLES(4), .LONG_TICKS(8)) dut (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .btn_in(btn_in),
        .btn_level(btn_level), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .long_pulse(long_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int kind; int cyc; } ev_t;
    ev_t exp_q[$];

    typedef struct {
        logic [31:0] pat;
        int          n;
        int          press_at;
        int          rel_at;
        int          long_at;
        logic        level;
    } vec_t;
    vec_t tbl[7];

    int n_cmp = 0, n_bad = 0;

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void push(int k, int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endfunction

    task automatic got_ev(int k);
        int ek, ec;
        ek = (exp_q.size() > 0) ? exp_q[0].kind : -1;
        ec = (exp_q.size() > 0) ? exp_q[0].cyc  : -1;
        chk("event_kind", k, ek);
        chk("event_cycle", cyc, ec);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (press_pulse || release_pulse)
                chk("press_release_same_cycle", int'(press_pulse & release_pulse), 0);
            if (press_pulse)   got_ev(K_PRESS);
            if (release_pulse) got_ev(K_REL);
            if (long_pulse)    got_ev(K_LONG);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; tick_in = 1'b0; btn_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One tick period with btn held at b; tc returns the tick_rise cycle.
    task automatic tick_once(input logic b, output int tc);
        btn_in = b;
        repeat (TP - 1) @(posedge clk);
        #1 tick_in = 1'b1;
        tc = cyc;
        @(posedge clk);
        #1 tick_in = 1'b0;
    endtask

    initial begin
        int tc;
        tbl[0] = '{32'h0000_000F,  8,  3,  7, -1, 1'b0};
        tbl[1] = '{32'h0000_00F7,  8,  7, -1, -1, 1'b1};
        tbl[2] = '{32'h0000_0055,  8, -1, -1, -1, 1'b0};
        tbl[3] = '{32'h0000_007F, 12,  3, 10, -1, 1'b0};
        tbl[4] = '{32'h0000_0077,  8, -1, -1, -1, 1'b0};
        tbl[5] = '{32'h0000_0FFF, 12,  3, -1, 11, 1'b1};
        tbl[6] = '{32'h000F_FFFF, 24,  3, 23, 11, 1'b0};

        // Reset with button held and tick high: outputs cleared.
        rst_n = 1'b0; btn_in = 1'b1; tick_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_level", int'(btn_level), 0);
        chk("reset_press", int'(press_pulse), 0);
        chk("reset_release", int'(release_pulse), 0);
        chk("reset_long", int'(long_pulse), 0);
        rst_n = 1'b1;
        // The first cycle out of reset sees a tick rise while the synchronizer
        // still holds 0, so it contributes a zero sample.
        @(posedge clk);
        #1 tick_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("reset_no_early_press", int'(btn_level), 0);
            tick_once(1'b1, tc);
            if (i == 3) push(K_PRESS, tc + 2);
        end
        repeat (4) @(posedge clk);
        #1 chk("reset_then_press_level", int'(btn_level), 1);

        // Table-driven tick patterns, each from a fresh reset.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            for (int i = 0; i < tbl[v].n; i++) begin
                tick_once(tbl[v].pat[i], tc);
                if (i == tbl[v].press_at) push(K_PRESS, tc + 2);
                if (i == tbl[v].rel_at)   push(K_REL, tc + 2);
                if (LONG_EN && i == tbl[v].long_at) push(K_LONG, tc + 1);
            end
            repeat (4) @(posedge clk);
            #1;
            chk($sformatf("vec%0d_level", v), int'(btn_level), int'(tbl[v].level));
            chk($sformatf("vec%0d_missing_events", v), exp_q.size(), 0);
        end

        // Bounce: 40-cycle toggles against a 64-cycle tick never give 4 equal samples.
        do_reset();
        fork
            begin
                repeat (15) begin
                    repeat (TP - 1) @(posedge clk);
                    #1 tick_in = 1'b1;
                    @(posedge clk);
                    #1 tick_in = 1'b0;
                end
            end
            begin
                btn_in = 1'b1;
                repeat (15) begin
                    repeat (40) @(posedge clk);
                    #1 btn_in = ~btn_in;
                end
                btn_in = 1'b0;
            end
        join
        #1 chk("bounce_level", int'(btn_level), 0);

        // Frozen tick low: button held without effect, then 4 ticks press.
        do_reset();
        btn_in = 1'b1;
        repeat (2000) @(posedge clk);
        #1 chk("frozen_low_level", int'(btn_level), 0);
        for (int i = 0; i < 4; i++) begin
            tick_once(1'b1, tc);
            if (i == 3) push(K_PRESS, tc + 2);
        end
        // Frozen tick high: one rise samples 1, then release is ignored.
        #1 tick_in = 1'b1;
        repeat (5) @(posedge clk);
        #1 btn_in = 1'b0;
        repeat (500) @(posedge clk);
        #1 chk("frozen_high_level", int'(btn_level), 1);
        tick_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick_once(1'b0, tc);
            if (i == 3) push(K_REL, tc + 2);
        end
        repeat (4) @(posedge clk);
        #1 chk("frozen_release_level", int'(btn_level), 0);

        // Reset while pressed: level drops at once, no release pulse,
        // full window needed again.
        for (int i = 0; i < 4; i++) begin
            tick_once(1'b1, tc);
            if (i == 3) push(K_PRESS, tc + 2);
        end
        repeat (4) @(posedge clk);
        #1 chk("midpress_level_before", int'(btn_level), 1);
        rst_n = 1'b0;
        #1 chk("midpress_async_clear", int'(btn_level), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("midpress_no_early_press", int'(btn_level), 0);
            tick_once(1'b1, tc);
            if (i == 3) push(K_PRESS, tc + 2);
        end
        repeat (10) @(posedge clk);
        #1;
        chk("final_level", int'(btn_level), 1);
        chk("final_missing_events", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
